// File: rtl/uart_rx_pkt_ctrl_pkg.sv
// Shared types and constants for the UART receive packet controller.
package uart_rx_pkt_ctrl_pkg;

    // Default start-of-packet marker
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Packet framing states
    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CSUM    = 3'd3,
        DROP    = 3'd4
    } rxState_t;

    // Bit positions inside the error pulse vector
    localparam int ERR_CSUM    = 0;
    localparam int ERR_LEN     = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_OVF     = 3;

    // Running 8-bit checksum: plain modulo-256 sum
    function automatic logic [7:0] csumAdd(input logic [7:0] acc, input logic [7:0] b);
        csumAdd = acc + b;
    endfunction

endpackage

// File: rtl/uart_rx_pkt_ctrl_fifo.sv
// Packet FIFO with a speculative write pointer: entries become readable only
// after commit; rollback discards everything written since the last commit.
module rx_pkt_fifo #(
    parameter int DEPTH = 32
) (
    input  logic                     clkRx,
    input  logic                     resetreg,
    input  logic                     wrEn,
    input  logic [8:0]               wrData,
    input  logic                     commit,
    input  logic                     rollback,
    input  logic                     rdEn,
    output logic [8:0]               rdData,
    output logic                     rdValid,
    output logic [$clog2(DEPTH):0]   freeSpace
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [8:0]    mem_r [DEPTH];
    logic [PW-1:0] specPtr_r;
    logic [PW-1:0] commitPtr_r;
    logic [PW-1:0] rdPtr_r;

    // Storage array: written at the speculative pointer
    always_ff @(posedge clkRx) begin
        if (wrEn) begin
            mem_r[specPtr_r[AW-1:0]] <= wrData;
        end
    end

    // Pointer maintenance; read and commit in the same cycle are independent
    always_ff @(posedge clkRx or posedge resetreg) begin
        if (resetreg) begin
            specPtr_r   <= {PW{1'b0}};
            commitPtr_r <= {PW{1'b0}};
            rdPtr_r     <= {PW{1'b0}};
        end else begin
            if (rollback) begin
                specPtr_r <= commitPtr_r;
            end else if (wrEn) begin
                specPtr_r <= specPtr_r + PW'(1);
            end
            if (commit) begin
                commitPtr_r <= specPtr_r;
            end
            if (rdEn && rdValid) begin
                rdPtr_r <= rdPtr_r + PW'(1);
            end
        end
    end

    assign rdValid   = (rdPtr_r != commitPtr_r);
    assign rdData    = rdValid ? mem_r[rdPtr_r[AW-1:0]] : 9'h000;
    assign freeSpace = PW'(DEPTH) - (specPtr_r - rdPtr_r);

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// UART receive packet controller: SYNC, LEN, N payload bytes, checksum.
// Payload is staged speculatively and released only on a good checksum.
module uart_rx_pkt_ctrl
    import uart_rx_pkt_ctrl_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int         MAX_LEN      = 16,
    parameter int         FIFO_DEPTH   = 32,
    parameter int         TIMEOUT_CLKS = 2000
) (
    input  logic       clkRx,
    input  logic       resetreg,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       rx_frame_err,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_csum,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_ovf,
    output logic [7:0] pkt_count
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CLKS);

    rxState_t      state_r, stateNext_s;
    logic [7:0]    cnt_r, csumAcc_r, pktCount_r;
    logic [TW-1:0] timer_r;
    logic [3:0]    errPulse_r, errNext_s;

    logic          byteOk_s, frameDrop_s, timeout_s;
    logic          lenBad_s, lenOvf_s, csumOk_s, lastByte_s;
    logic          fifoWr_s, fifoCommit_s, fifoRollback_s, rdValid_s;
    logic [8:0]    rdData_s;
    logic [PW-1:0] freeSpace_s;
    logic [7:0]    freeSpace8_s;

    assign freeSpace8_s = 8'(freeSpace_s);
    assign byteOk_s     = rx_valid & ~rx_frame_err;
    assign frameDrop_s  = rx_valid & rx_frame_err & (state_r != HUNT);
    assign timeout_s    = ~rx_valid & (state_r != HUNT) & (timer_r == TW'(TIMEOUT_CLKS - 1));
    assign lenBad_s     = (rx_byte == 8'h00) | (rx_byte > 8'(MAX_LEN));
    assign lenOvf_s     = ~lenBad_s & (freeSpace8_s < rx_byte);
    assign lastByte_s   = (cnt_r == 8'd1);
    assign csumOk_s     = (rx_byte == csumAcc_r);

    // State register
    always_ff @(posedge clkRx or posedge resetreg) begin
        if (resetreg) begin
            state_r <= HUNT;
        end else begin
            state_r <= stateNext_s;
        end
    end

    // Next-state decode; timeout and framing errors abort any packet
    always_comb begin
        stateNext_s = state_r;
        if (timeout_s || frameDrop_s) begin
            stateNext_s = HUNT;
        end else if (byteOk_s) begin
            case (state_r)
                HUNT:    stateNext_s = (rx_byte == SYNC_BYTE) ? LEN : HUNT;
                LEN:     stateNext_s = lenBad_s ? HUNT : (lenOvf_s ? DROP : PAYLOAD);
                PAYLOAD: stateNext_s = lastByte_s ? CSUM : PAYLOAD;
                CSUM:    stateNext_s = HUNT;
                DROP:    stateNext_s = lastByte_s ? HUNT : DROP;
                default: stateNext_s = HUNT;
            endcase
        end else begin
            stateNext_s = state_r;
        end
    end

    // FIFO control and error pulse decode
    always_comb begin
        fifoWr_s       = 1'b0;
        fifoCommit_s   = 1'b0;
        fifoRollback_s = 1'b0;
        errNext_s      = 4'b0000;
        if (timeout_s) begin
            fifoRollback_s         = 1'b1;
            errNext_s[ERR_TIMEOUT] = 1'b1;
        end else if (frameDrop_s) begin
            fifoRollback_s = 1'b1;
        end else if (byteOk_s) begin
            case (state_r)
                LEN: begin
                    if (lenBad_s) begin
                        errNext_s[ERR_LEN] = 1'b1;
                    end else begin
                        errNext_s[ERR_OVF] = lenOvf_s;
                    end
                end
                PAYLOAD: fifoWr_s = 1'b1;
                CSUM: begin
                    if (csumOk_s) begin
                        fifoCommit_s = 1'b1;
                    end else begin
                        fifoRollback_s      = 1'b1;
                        errNext_s[ERR_CSUM] = 1'b1;
                    end
                end
                default: fifoWr_s = 1'b0;
            endcase
        end else begin
            fifoWr_s = 1'b0;
        end
    end

    // Datapath registers: byte counter, checksum, timeout timer, stats, pulses
    always_ff @(posedge clkRx or posedge resetreg) begin
        if (resetreg) begin
            cnt_r      <= 8'd0;
            csumAcc_r  <= 8'd0;
            timer_r    <= {TW{1'b0}};
            pktCount_r <= 8'd0;
            errPulse_r <= 4'b0000;
        end else begin
            errPulse_r <= errNext_s;
            if (rx_valid || timeout_s || (state_r == HUNT)) begin
                timer_r <= {TW{1'b0}};
            end else begin
                timer_r <= timer_r + TW'(1);
            end
            if (byteOk_s && (state_r == LEN)) begin
                cnt_r     <= lenOvf_s ? (rx_byte + 8'd1) : rx_byte;
                csumAcc_r <= rx_byte;
            end else if (byteOk_s && (state_r == PAYLOAD)) begin
                cnt_r     <= cnt_r - 8'd1;
                csumAcc_r <= csumAdd(csumAcc_r, rx_byte);
            end else if (byteOk_s && (state_r == DROP)) begin
                cnt_r <= cnt_r - 8'd1;
            end
            if (fifoCommit_s) begin
                pktCount_r <= pktCount_r + 8'd1;
            end
        end
    end

    rx_pkt_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clkRx     (clkRx),
        .resetreg  (resetreg),
        .wrEn      (fifoWr_s),
        .wrData    ({lastByte_s, rx_byte}),
        .commit    (fifoCommit_s),
        .rollback  (fifoRollback_s),
        .rdEn      (out_ready),
        .rdData    (rdData_s),
        .rdValid   (rdValid_s),
        .freeSpace (freeSpace_s)
    );

    assign out_data    = rdData_s[7:0];
    assign out_last    = rdData_s[8];
    assign out_valid   = rdValid_s;
    assign err_csum    = errPulse_r[ERR_CSUM];
    assign err_len     = errPulse_r[ERR_LEN];
    assign err_timeout = errPulse_r[ERR_TIMEOUT];
    assign err_ovf     = errPulse_r[ERR_OVF];
    assign pkt_count   = pktCount_r;

endmodule
